// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART transmit buffer slice.
//   UART_DATA_W    : byte width carried through buffer and transmitter handshake
//   launch_state_e : launch controller states
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } launch_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: system-side write port, buffer status and transmitter
// handshake of uart_tx_fifo.
//   master : drives wr_en/wr_data (system) and uart_tx_busy (transmitter)
//   slave  : the buffer; drives status flags and the launch pulse/data
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  import uart_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   full;
  logic                   empty;
  logic [ADDR_W:0]        count;
  logic                   overflow;
  logic                   uart_tx_en;
  logic [UART_DATA_W-1:0] uart_tx_data;
  logic                   uart_tx_busy;

  modport master (
    output wr_en, wr_data, uart_tx_busy,
    input  full, empty, count, overflow, uart_tx_en, uart_tx_data
  );

  modport slave (
    input  wr_en, wr_data, uart_tx_busy,
    output full, empty, count, overflow, uart_tx_en, uart_tx_data
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: DEPTH x 8 circular byte buffer.
//   clk, reset        : clock, async active-high reset (flushes pointers/count)
//   wr_en, wr_data    : enqueue when wr_en && !full
//   rd_en, rd_data    : rd_data shows head entry; rd_en && !empty pops it
//   full, empty, count: occupancy, derived from the registered count
//   overflow          : one-cycle pulse after a write attempt while full
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      wp, rp;
  logic                   wr_ok, rd_ok;

  // Count is kept separately from the pointers so wp == rp is never ambiguous.
  // A write while full is refused even if a pop lands on the same edge.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rp];

  // Storage carries no reset; a flush only needs pointers and count cleared.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + ADDR_W'(1);
      if (rd_ok) rp <= rp + ADDR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      overflow <= wr_en && full;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte buffer plus launch controller feeding a UART transmitter.
//   clk   : system / transmitter clock
//   reset : async active-high; flushes buffer, controller back to idle
//   bus   : uart_tx_fifo_if.slave
//           wr_en/wr_data in, full/empty/count/overflow out,
//           uart_tx_en/uart_tx_data out (registered), uart_tx_busy in
// One byte is in flight at a time: pop into the data register, pulse
// uart_tx_en for one cycle, then follow busy up and back down.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  launch_state_e          state_q, state_d;
  logic                   pop;
  logic [UART_DATA_W-1:0] head_data;
  logic                   fifo_full, fifo_empty, fifo_ovf;
  logic [ADDR_W:0]        fifo_count;
  logic                   tx_en_q;
  logic [UART_DATA_W-1:0] tx_data_q;

  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (pop),
    .rd_data  (head_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (fifo_ovf)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !bus.uart_tx_busy) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      // Waiting for busy to rise first keeps a stale low busy from
      // releasing the next byte before the transmitter has taken this one.
      S_WAIT_BUSY: if (bus.uart_tx_busy)  state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!bus.uart_tx_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q <= state_d;
      tx_en_q <= (state_d == S_LAUNCH);
      // Data is captured at the pop and held until the next pop, which
      // cannot happen before busy has fallen.
      if (pop) tx_data_q <= head_data;
    end
  end

  assign bus.full         = fifo_full;
  assign bus.empty        = fifo_empty;
  assign bus.count        = fifo_count;
  assign bus.overflow     = fifo_ovf;
  assign bus.uart_tx_en   = tx_en_q;
  assign bus.uart_tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a behavioural
// transmitter (start, 8 data LSB-first, stop; bc clocks per bit) and a
// line receiver that decodes the serial line back into bytes.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs are driven and outputs sampled 2 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ---------------- transmitter model (acts on negedge) ----------------
  bit         force_busy = 1'b0;
  int         bc = 2;
  logic       line = 1'b1;
  logic       model_busy = 1'b0;
  bit         pend = 1'b0;
  int         mcnt = 0;
  logic [9:0] frame = '0;
  int         cyc_n = 0;
  int         fall_cyc = -1;
  int         en_cnt = 0;
  int         launch_while_busy = 0;
  int         data_unstable = 0;
  int         gaps_q[$];

  initial begin
    bus.uart_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (reset) begin
        model_busy = 1'b0;
        pend       = 1'b0;
        mcnt       = 0;
        line       = 1'b1;
      end else begin
        if (bus.uart_tx_en) begin
          en_cnt++;
          if (model_busy || pend) launch_while_busy++;
          if (fall_cyc >= 0) gaps_q.push_back(cyc_n - fall_cyc);
        end
        if (pend) begin
          pend       = 1'b0;
          model_busy = 1'b1;
          mcnt       = 0;
        end else if (model_busy) begin
          mcnt++;
          if (mcnt == 10*bc) begin
            model_busy = 1'b0;
            line       = 1'b1;
            fall_cyc   = cyc_n;
          end
        end
        if (model_busy) begin
          line = frame[mcnt/bc];
          if (bus.uart_tx_data !== frame[8:1]) data_unstable++;
        end
        if (bus.uart_tx_en && !model_busy && !pend && !force_busy) begin
          pend  = 1'b1;
          frame = {1'b1, bus.uart_tx_data, 1'b0};
        end
      end
      bus.uart_tx_busy = model_busy || force_busy;
    end
  end

  // ---------------- line receiver (samples on posedge) ----------------
  logic [7:0] rx_q[$];
  int         frm_err = 0;
  bit         rx_act = 1'b0;
  int         rx_ph = 0;
  logic [7:0] rx_sh = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (line === 1'b0) begin
          rx_act = 1'b1;
          rx_ph  = 0;
        end
      end else begin
        rx_ph++;
        if ((rx_ph % bc) == bc/2) begin
          int k;
          k = rx_ph / bc;
          if (k == 0) begin
            if (line !== 1'b0) frm_err++;
          end else if (k <= 8) begin
            rx_sh[k-1] = line;
          end else begin
            if (line !== 1'b1) frm_err++;
            rx_q.push_back(rx_sh);
            rx_act = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_rx(input int n, input int max_cyc);
    int i;
    i = 0;
    while (rx_q.size() < n && i < max_cyc) begin
      cyc();
      i++;
    end
    check("rx_byte_count", rx_q.size(), n);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int r0, e0, d0, lw0, g0, n, guard, ovf_seen;

    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 8'(i + 1), 5'(i + 1), (i == 15), 1'b0, 1'b0};
    vecs[16] = '{1'b1, 8'hFF, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 8'hFF, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 5'd16, 1'b1, 1'b0, 1'b0};

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;

    // Reset values
    repeat (3) cyc();
    check("rst_full",   bus.full, 0);
    check("rst_empty",  bus.empty, 1);
    check("rst_count",  bus.count, 0);
    check("rst_ovf",    bus.overflow, 0);
    check("rst_tx_en",  bus.uart_tx_en, 0);
    check("rst_tx_data", bus.uart_tx_data, 8'h00);
    reset = 1'b0;
    cyc();

    // Single byte: write in cycle 0, empty low cycle 1, launch cycle 2
    r0 = rx_q.size(); e0 = en_cnt;
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    cyc();
    bus.wr_en = 1'b0;
    check("c1_empty", bus.empty, 0);
    check("c1_count", bus.count, 1);
    check("c1_tx_en", bus.uart_tx_en, 0);
    cyc();
    check("c2_tx_en",   bus.uart_tx_en, 1);
    check("c2_tx_data", bus.uart_tx_data, 8'hA5);
    check("c2_empty",   bus.empty, 1);
    cyc();
    check("c3_tx_en", bus.uart_tx_en, 0);
    wait_rx(r0 + 1, 200);
    check("single_rx", rx_q[r0], 8'hA5);
    repeat (10) cyc();
    check("single_en_cnt", en_cnt - e0, 1);
    check("single_frm_err", frm_err, 0);

    // Fill to full with the transmitter held busy, then overflow attempts
    force_busy = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 20; i++) begin
      bus.wr_en   = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      cyc();
      check($sformatf("v%0d_count", i), bus.count, vecs[i].exp_count);
      check($sformatf("v%0d_full", i),  bus.full,  vecs[i].exp_full);
      check($sformatf("v%0d_empty", i), bus.empty, vecs[i].exp_empty);
      check($sformatf("v%0d_ovf", i),   bus.overflow, vecs[i].exp_ovf);
      check($sformatf("v%0d_tx_en", i), bus.uart_tx_en, 0);
    end
    bus.wr_en = 1'b0;

    // Release: all 16 bytes drain in order, one launch each, 0xFF never sent
    r0 = rx_q.size(); e0 = en_cnt; g0 = gaps_q.size();
    force_busy = 1'b0;
    wait_rx(r0 + 16, 3000);
    for (int i = 0; i < 16; i++)
      check($sformatf("burst_rx%0d", i), rx_q[r0+i], 8'(i + 1));
    repeat (10) cyc();
    check("burst_en_cnt", en_cnt - e0, 16);
    check("burst_empty", bus.empty, 1);
    check("burst_count", bus.count, 0);
    check("burst_gap", (gaps_q.size() > g0) ? gaps_q[$] : -1, 2);

    // Simultaneous write and pop at count 3
    force_busy = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h30 + i);
      cyc();
    end
    bus.wr_en = 1'b0;
    cyc();
    check("sim_pre_count", bus.count, 3);
    r0 = rx_q.size();
    force_busy  = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h33;
    cyc();
    bus.wr_en = 1'b0;
    check("sim_count", bus.count, 3);
    check("sim_tx_en", bus.uart_tx_en, 1);
    check("sim_tx_data", bus.uart_tx_data, 8'h30);
    wait_rx(r0 + 4, 500);
    for (int i = 0; i < 4; i++)
      check($sformatf("sim_rx%0d", i), rx_q[r0+i], 8'(8'h30 + i));
    repeat (10) cyc();

    // Wrap-around: 40 bytes, writing whenever not full
    r0 = rx_q.size(); n = 0; guard = 0; ovf_seen = 0;
    while (n < 40 && guard < 5000) begin
      if (bus.overflow) ovf_seen++;
      if (!bus.full) begin
        bus.wr_en = 1'b1; bus.wr_data = 8'(8'h40 + n);
        n++;
      end else begin
        bus.wr_en = 1'b0;
      end
      cyc();
      guard++;
    end
    bus.wr_en = 1'b0;
    check("wrap_written", n, 40);
    wait_rx(r0 + 40, 3000);
    for (int i = 0; i < 40; i++)
      check($sformatf("wrap_rx%0d", i), rx_q[r0+i], 8'(8'h40 + i));
    check("wrap_ovf", ovf_seen, 0);
    repeat (10) cyc();
    check("wrap_empty", bus.empty, 1);

    // Long busy: 100-cycle frames, next launch exactly 2 cycles after busy falls
    bc = 10;
    r0 = rx_q.size(); e0 = en_cnt; d0 = data_unstable; lw0 = launch_while_busy;
    bus.wr_en = 1'b1; bus.wr_data = 8'hC3;
    cyc();
    bus.wr_data = 8'h3C;
    cyc();
    bus.wr_en = 1'b0;
    wait_rx(r0 + 2, 600);
    repeat (10) cyc();
    check("long_rx0", rx_q[r0], 8'hC3);
    check("long_rx1", rx_q[r0+1], 8'h3C);
    check("long_en_cnt", en_cnt - e0, 2);
    check("long_gap", gaps_q[$], 2);
    check("long_data_stable", data_unstable - d0, 0);
    check("long_en_while_busy", launch_while_busy - lw0, 0);
    check("long_frm_err", frm_err, 0);

    // Reset mid-stream
    bc = 2;
    e0 = en_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(8'h50 + i);
      cyc();
    end
    bus.wr_en = 1'b0;
    guard = 0;
    while (en_cnt < e0 + 2 && guard < 200) begin
      cyc();
      guard++;
    end
    check("mid_launches", en_cnt - e0, 2);
    repeat (5) cyc();
    reset = 1'b1;
    #1;
    check("mrst_full",   bus.full, 0);
    check("mrst_empty",  bus.empty, 1);
    check("mrst_count",  bus.count, 0);
    check("mrst_ovf",    bus.overflow, 0);
    check("mrst_tx_en",  bus.uart_tx_en, 0);
    check("mrst_tx_data", bus.uart_tx_data, 8'h00);
    repeat (2) cyc();
    reset = 1'b0;
    e0 = en_cnt;
    repeat (50) cyc();
    check("post_rst_en_cnt", en_cnt - e0, 0);
    check("post_rst_empty", bus.empty, 1);
    check("post_rst_count", bus.count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
